datapath: RTL
=============

// Module: datapath
// PURPOSE
//   Execution datapath directly downstream of the control unit: consumes D_addr/D_wr/RF_s/
//   RF_*_addr/RF_*_wr/RF_*_rd/Alu_s0 each cycle and performs the data-memory, register-file
//   and ALU work for LOAD/STORE/ADD/SUB/etc. Contains 256x16 data RAM, 16x16 register file,
//   registered A/B read latches, 8-op ALU and RF write-data mux. Exposes results for debug/display.
// PARAMETERS
//   DATA_W      16  datapath word width
//   RF_AW        4  register-file address width (2**RF_AW registers)
//   DM_AW        8  data-memory address width (2**DM_AW words)
// PORTS
//   Clock       in   1        rising-edge clock
//   Resetn      in   1        asynchronous reset, active low
//   D_addr      in   DM_AW    data-memory address
//   D_wr        in   1        data-memory write enable
//   RF_s        in   1        RF write-data select: 1 = memory read data, 0 = ALU result
//   RF_W_addr   in   RF_AW    RF write address
//   RF_W_wr     in   1        RF write enable
//   RF_Ra_addr  in   RF_AW    RF read port A address
//   RF_Ra_rd    in   1        load A latch
//   RF_Rb_addr  in   RF_AW    RF read port B address
//   RF_Rb_rd    in   1        load B latch
//   Alu_s0      in   3        ALU operation select
//   ALU_A       out  DATA_W   A latch (ALU operand A, memory write data)
//   ALU_B       out  DATA_W   B latch (ALU operand B)
//   ALU_Out     out  DATA_W   ALU result (combinational from latches)
//   D_q         out  DATA_W   data-memory read data (registered)
//   RF_W_data   out  DATA_W   value presented to RF write port
//   Zero        out  1        ALU_Out == 0
// BEHAVIOUR
//   Reset (Resetn=0, async, no clock needed): all 16 RF registers, ALU_A, ALU_B, D_q -> 0;
//     hence ALU_Out = 0 (for Alu_s0=0), Zero = 1, RF_W_data = 0 or per mux. Data RAM
//     contents NOT cleared. Reset mid-operation aborts any write on that edge.
//   Data memory: on posedge, D_q <= mem[D_addr] (old contents); if D_wr, mem[D_addr] <= ALU_A.
//     Read latency 1 cycle. Same-edge read+write same address: D_q returns OLD data.
//   Register file: on posedge, if RF_W_wr, RF[RF_W_addr] <= RF_W_data.
//   A/B latches: on posedge, if RF_Ra_rd ALU_A <= RF[RF_Ra_addr], else hold; same for B.
//     Bypass: if RF_W_wr and write addr == read addr on same edge, latch takes RF_W_data.
//   RF_W_data = RF_s ? D_q : ALU_Out (combinational).
//   ALU (Alu_s0): 0 -> 0; 1 -> A+B; 2 -> A-B; 3 -> A; 4 -> A^B; 5 -> A|B; 6 -> A&B; 7 -> A+1.
//     Arithmetic mod 2**DATA_W, unsigned, carry/borrow discarded; no flags besides Zero.
//   Undriven/X control inputs are the upstream block's fault; no internal sanitising.
//   Typical op timing (driven by control unit): LOAD Rw<-M[a]: cyc n D_addr=a; cyc n+1
//     RF_s=1, RF_W_wr=1 -> RF updated at end of n+1. STORE M[a]<-Ra: cyc n Ra_rd; cyc n+1
//     D_addr=a, D_wr=1. ADD: cyc n Ra_rd,Rb_rd; cyc n+1 Alu_s0=1, RF_s=0, RF_W_wr=1.
// TESTING
//   1 Reset: drive Resetn=0 mid-cycle -> ALU_A=ALU_B=D_q=0, Zero=1 immediately, no clock edge.
//   2 RF write/read: write 16'h1234 to R3 via RF_s=0, Alu_s0=3 path after loading A; read R3
//     into A next cycle -> ALU_A=16'h1234; R0..R15 others still 0.
//   3 Store/load: A=16'h00AB, D_wr=1 D_addr=8'h10; next cycle read 8'h10 -> D_q=16'h00AB one
//     cycle after address; RF_s=1 write to R5 -> R5=16'h00AB.
//   4 ALU sweep: A=16'hFFFF, B=16'h0001 -> op1=16'h0000 Zero=1, op2=16'hFFFE, op4=16'hFFFE,
//     op5=16'hFFFF, op6=16'h0001, op7=16'h0000, op0=16'h0000.
//   5 Collisions: RF write R2=16'h5555 with Ra_rd R2 same edge -> ALU_A=16'h5555; mem write
//     8'h20 new=16'h7777 with read 8'h20 same edge -> D_q=old value, next read=16'h7777.

Source files
------------

// File: rtl/datapath.sv
// datapath: data RAM, register file, A/B operand latches and 8-op ALU below the control unit.
module datapath #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4,
  parameter int DM_AW  = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic [DM_AW-1:0]  D_addr,
  input  logic              D_wr,
  input  logic              RF_s,
  input  logic [RF_AW-1:0]  RF_W_addr,
  input  logic              RF_W_wr,
  input  logic [RF_AW-1:0]  RF_Ra_addr,
  input  logic              RF_Ra_rd,
  input  logic [RF_AW-1:0]  RF_Rb_addr,
  input  logic              RF_Rb_rd,
  input  logic [2:0]        Alu_s0,
  output logic [DATA_W-1:0] ALU_A,
  output logic [DATA_W-1:0] ALU_B,
  output logic [DATA_W-1:0] ALU_Out,
  output logic [DATA_W-1:0] D_q,
  output logic [DATA_W-1:0] RF_W_data,
  output logic              Zero
);
  logic [DATA_W-1:0] mem [2**DM_AW];
  logic [DATA_W-1:0] rf  [2**RF_AW];
  assign RF_W_data = RF_s ? D_q : ALU_Out;
  assign Zero      = ALU_Out == '0;
  always_comb begin
    ALU_Out = '0;
    case (Alu_s0)
      3'd1: ALU_Out = ALU_A + ALU_B;
      3'd2: ALU_Out = ALU_A - ALU_B;
      3'd3: ALU_Out = ALU_A;
      3'd4: ALU_Out = ALU_A ^ ALU_B;
      3'd5: ALU_Out = ALU_A | ALU_B;
      3'd6: ALU_Out = ALU_A & ALU_B;
      3'd7: ALU_Out = ALU_A + DATA_W'(1);
      default: ALU_Out = '0;
    endcase
  end
  // RAM contents survive reset; only the read register clears, and reset blocks the write
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) D_q <= '0;
    else begin
      D_q <= mem[D_addr];
      if (D_wr) mem[D_addr] <= ALU_A;
    end
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      for (int i = 0; i < 2**RF_AW; i++) rf[i] <= '0;
      ALU_A <= '0;
      ALU_B <= '0;
    end else begin
      if (RF_W_wr) rf[RF_W_addr] <= RF_W_data;
      if (RF_Ra_rd) ALU_A <= (RF_W_wr && RF_W_addr == RF_Ra_addr) ? RF_W_data : rf[RF_Ra_addr];
      if (RF_Rb_rd) ALU_B <= (RF_W_wr && RF_W_addr == RF_Rb_addr) ? RF_W_data : rf[RF_Rb_addr];
    end
endmodule
